// File: rtl/al_accel_pkg.sv
// -----------------------------------------------------------------------------
// al_accel_pkg
// Shared defaults for the accelerator pipeline (line buffer, ireg, MAC stages).
// Holds the pixel width and the default image geometry so every stage agrees
// on the frame shape without repeating literals.
// No ports (package).
// -----------------------------------------------------------------------------
package al_accel_pkg;

   localparam int unsigned AL_DATA_W = 8;    // pixel width in bits
   localparam int unsigned AL_IMG_W  = 28;   // pixels per row
   localparam int unsigned AL_IMG_H  = 28;   // rows per frame

endpackage

// File: rtl/al_accel_linemem.sv
// -----------------------------------------------------------------------------
// al_accel_linemem
// One image row of storage: DEPTH entries of WIDTH bits, combinational read,
// synchronous write. Contents are not reset; consumers mask stale data.
//
// Ports:
//   clk    in   system clock, rising edge
//   we     in   write enable
//   addr   in   shared read/write address (column)
//   wdata  in   write data
//   rdata  out  combinational read of mem[addr] (old value on a write cycle)
// -----------------------------------------------------------------------------
module al_accel_linemem
   import al_accel_pkg::*;
#(
   parameter int unsigned DEPTH = AL_IMG_W,
   parameter int unsigned WIDTH = AL_DATA_W,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Read-before-write falls out naturally: rdata shows the pre-edge value.
   assign rdata = mem[addr];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

endmodule

// File: rtl/al_accel_linebuf.sv
// -----------------------------------------------------------------------------
// al_accel_linebuf
// Line buffer feeding al_accel_ireg. Takes a raster-order pixel stream, keeps
// the two previous rows in line memories and emits three vertically aligned
// pixels (rows r-2, r-1, r) per column, one cycle after each accepted pixel.
//
// Build option: define AL_ACCEL_LINEBUF_ZERO_PAD_EN for top zero padding
// (rows above the frame read as 0 and enb fires for every pixel).
//
// Ports:
//   clk          in   system clock, rising edge
//   resetn       in   asynchronous active-low reset
//   pix_di       in   input pixel
//   pix_valid    in   pixel valid; always accepted
//   frame_start  in   restart counters at row 0, col 0 (applies to this cycle)
//   ireg_di_0    out  row r-2 pixel
//   ireg_di_1    out  row r-1 pixel
//   ireg_di_2    out  row r pixel
//   ireg_enb     out  window column valid
//   ireg_sol     out  start of line (col 0 output)
//   frame_done   out  pulse aligned with the last output of a frame
// -----------------------------------------------------------------------------
module al_accel_linebuf
   import al_accel_pkg::*;
#(
   parameter int unsigned DATA_W = AL_DATA_W,
   parameter int unsigned IMG_W  = AL_IMG_W,
   parameter int unsigned IMG_H  = AL_IMG_H,
   localparam int unsigned COL_W = $clog2(IMG_W),
   localparam int unsigned ROW_W = $clog2(IMG_H)
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [DATA_W-1:0] pix_di,
   input  logic              pix_valid,
   input  logic              frame_start,
   output logic [DATA_W-1:0] ireg_di_0,
   output logic [DATA_W-1:0] ireg_di_1,
   output logic [DATA_W-1:0] ireg_di_2,
   output logic              ireg_enb,
   output logic              ireg_sol,
   output logic              frame_done
);

   logic [COL_W-1:0]  col_q, col_d, cur_col;
   logic [ROW_W-1:0]  row_q, row_d, cur_row;
   logic              last_col, last_row;
   logic [DATA_W-1:0] rd_line0, rd_line1;
   logic [DATA_W-1:0] nxt_di_0, nxt_di_1;
   logic              nxt_enb;

   // frame_start overrides the stored position in the same cycle so a pixel
   // arriving with it lands at row 0, col 0.
   always_comb begin
      cur_col  = frame_start ? '0 : col_q;
      cur_row  = frame_start ? '0 : row_q;
      last_col = (cur_col == COL_W'(IMG_W - 1));
      last_row = (cur_row == ROW_W'(IMG_H - 1));
      col_d    = cur_col;
      row_d    = cur_row;
      if (pix_valid) begin
         if (last_col) begin
            col_d = '0;
            row_d = last_row ? '0 : cur_row + ROW_W'(1);
         end else begin
            col_d = cur_col + COL_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

   // line0 holds row r-1; line1 holds row r-2 and is refilled from line0's
   // old value at the same column, shifting the two rows down together.
   al_accel_linemem #(
      .DEPTH (IMG_W),
      .WIDTH (DATA_W)
   ) u_line0 (
      .clk   (clk),
      .we    (pix_valid),
      .addr  (cur_col),
      .wdata (pix_di),
      .rdata (rd_line0)
   );

   al_accel_linemem #(
      .DEPTH (IMG_W),
      .WIDTH (DATA_W)
   ) u_line1 (
      .clk   (clk),
      .we    (pix_valid),
      .addr  (cur_col),
      .wdata (rd_line0),
      .rdata (rd_line1)
   );

`ifdef AL_ACCEL_LINEBUF_ZERO_PAD_EN
   // Rows above the frame read as zero; every pixel yields a window column.
   always_comb begin
      nxt_di_0 = (cur_row < ROW_W'(2)) ? '0 : rd_line1;
      nxt_di_1 = (cur_row == '0)       ? '0 : rd_line0;
      nxt_enb  = 1'b1;
   end
`else
   // Stale memory contents in rows 0/1 are masked by holding enb low.
   always_comb begin
      nxt_di_0 = rd_line1;
      nxt_di_1 = rd_line0;
      nxt_enb  = (cur_row >= ROW_W'(2));
   end
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ireg_di_0  <= '0;
         ireg_di_1  <= '0;
         ireg_di_2  <= '0;
         ireg_enb   <= 1'b0;
         ireg_sol   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         ireg_enb   <= pix_valid & nxt_enb;
         ireg_sol   <= pix_valid & (cur_col == '0);
         frame_done <= pix_valid & last_col & last_row;
         // Data outputs hold across bubbles.
         if (pix_valid) begin
            ireg_di_0 <= nxt_di_0;
            ireg_di_1 <= nxt_di_1;
            ireg_di_2 <= pix_di;
         end
      end
   end

endmodule

// File: doc/al_accel_linebuf.md
Name: al_accel_linebuf

Overview:
Line buffer directly upstream of the accelerator input register stage (al_accel_ireg). It accepts a raster-order 8-bit pixel stream, stores the two previous image rows, and emits three vertically aligned bytes per column (rows r-2, r-1, r) plus the enb strobe that drives the three ireg data inputs. Together with the ireg column shift, this forms the 3x3 convolution window for the accelerator datapath.

Parameters:
DATA_W, 8, pixel width in bits
IMG_W, 28, pixels per row (minimum 3)
IMG_H, 28, rows per frame (minimum 3)
COL_W, $clog2(IMG_W), column counter width (derived, not overridden)
ROW_W, $clog2(IMG_H), row counter width (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
resetn  in  1  reset; one clock, asynchronous active-low
pix_di  in  DATA_W  input pixel
pix_valid  in  1  pix_di valid this cycle; no backpressure, always accepted
frame_start  in  1  pulse that restarts the counters at row 0, col 0
ireg_di_0  out  DATA_W  pixel of row r-2, same column
ireg_di_1  out  DATA_W  pixel of row r-1, same column
ireg_di_2  out  DATA_W  pixel of row r (the current input)
ireg_enb  out  1  window column valid; drives ireg enb
ireg_sol  out  1  start of line; high with the col-0 output
frame_done  out  1  one-cycle pulse after the last pixel of a frame

Behaviour:
- Reset (async, resetn=0): col=0, row=0; all outputs 0. Line memories are not reset; their stale contents are masked by enb gating.
- Storage: two IMG_W x DATA_W line memories, line0 (row r-1) and line1 (row r-2). Combinational read, synchronous write.
- On each cycle with pix_valid=1 at column c:
  - read a=line0[c] and b=line1[c];
  - write line1[c]<=a and line0[c]<=pix_di, using read-before-write at the same address;
  - register the outputs ireg_di_0<=b, ireg_di_1<=a, ireg_di_2<=pix_di.
- Output timing:
  - ireg_enb<=(row>=2); ireg_sol<=(c==0).
  - Latency is exactly 1 cycle from the pix_valid cycle.
  - On cycles with pix_valid=0, ireg_enb=0 and ireg_sol=0; the data outputs hold their values.
- Counters:
  - col increments per valid pixel. At col==IMG_W-1 it wraps to 0 and row increments.
  - At row==IMG_H-1 and col==IMG_W-1, row wraps to 0 and frame_done pulses on the next cycle, aligned with the last output.
- frame_start:
  - Resets col and row to 0 in the same cycle.
  - If frame_start and pix_valid are both high, that pixel is col 0, row 0 of the new frame.
  - If frame_start arrives mid-frame, the partial frame is abandoned and no frame_done is issued for it.
- Bubbles: gaps in pix_valid never advance the counters or corrupt the memories.
- Reset mid-frame: outputs go to 0 immediately; the next pixel is treated as row 0, col 0.
- Count: a full frame yields exactly (IMG_H-2)*IMG_W enb pulses.

Optional Feature:
AL_ACCEL_LINEBUF_ZERO_PAD_EN
- When defined: top zero padding. For row 0, ireg_di_0 and ireg_di_1 output 0. For row 1, ireg_di_0 outputs 0. ireg_enb is high for every valid pixel, giving IMG_H*IMG_W pulses per frame.
- When undefined: behaviour is exactly as specified above (no padding; enb only for row>=2).

Decomposition:
- Shared package al_accel_pkg: DATA_W default and IMG_W/IMG_H defaults, shared with ireg and the MAC stages.
- Sub-module al_accel_linemem: one IMG_W-deep memory with combinational read and synchronous write; instantiate it twice.
- Counters and output registers live in the top module.

Test Plan (IMG_W=4, IMG_H=4, pix_di=row*16+col):
1. Stream one full frame with pix_valid continuous.
   - Input 0x21 → next cycle di_0=0x01, di_1=0x11, di_2=0x21, enb=1, sol=0.
   - Exactly 8 enb pulses in total; frame_done pulse in the cycle after 0x33 is input.
2. Same frame with pix_valid alternating 1/0.
   - Identical output sequence at half rate; enb never high on an idle-following cycle.
3. frame_start asserted together with the pixel at row 2, col 2, then restart the stream.
   - No enb until the new row 2; no frame_done for the aborted frame.
4. resetn=0 for 2 cycles mid-row 3.
   - All outputs 0 at once; the next frame behaves exactly as in scenario 1.
5. Two back-to-back frames, the second with values +0x80.
   - Second-frame row 2 output is di_0=0x81, di_1=0x91, di_2=0xA1 at col 1; no first-frame data leaks.
6. AL_ACCEL_LINEBUF_ZERO_PAD_EN defined.
   - Input 0x00 → di_0=0, di_1=0, di_2=0x00, enb=1, sol=1.
   - Input 0x12 → di_0=0, di_1=0x02.
   - 16 enb pulses per frame.
